wb_arbiter: RTL and testbench

Writeback arbiter directly upstream of the register file, which has a single write port. Merges two result sources into that one registered write port:
- the in-order pipeline writeback result;
- results from long-latency units (divider, load miss), buffered in a small FIFO.

The block also generates a pipeline stall when the pipeline result loses arbitration.

---
 rtl/wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the in-order pipeline result and a small long-latency FIFO onto the
// single register-file write port. Define WB_ARB_BYPASS_EN to enable the pending-write bypass outputs.
module wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4,
   parameter int XLEN       = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     pipe_valid_i,
   input  logic [4:0]               pipe_rd_addr_i,
   input  logic [XLEN-1:0]          pipe_data_i,
   input  logic                     lu_valid_i,
   input  logic [4:0]               lu_rd_addr_i,
   input  logic [XLEN-1:0]          lu_data_i,
   output logic                     lu_ready_o,
   output logic                     stall_o,
   output logic                     rf_we_o,
   output logic [4:0]               rf_rd_addr_o,
   output logic [XLEN-1:0]          rf_wdata_o,
   input  logic [4:0]               rs1_addr_i,
   input  logic [4:0]               rs2_addr_i,
   output logic                     rs1_fwd_valid_o,
   output logic [XLEN-1:0]          rs1_fwd_data_o,
   output logic                     rs2_fwd_valid_o,
   output logic [XLEN-1:0]          rs2_fwd_data_o,
   output logic [$clog2(DEPTH):0]   buf_count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]      addr_mem [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;

   logic            full, empty, push, grant_fifo, grant_pipe;
   logic [4:0]      head_addr;
   logic [XLEN-1:0] head_data;

   always_comb begin
      full       = (count_q == CW'(DEPTH));
      empty      = (count_q == '0);
      head_addr  = addr_mem[rd_ptr_q];
      head_data  = data_mem[rd_ptr_q];
      // Head wins when full or starved; otherwise pipeline first, FIFO only in idle slots.
      grant_fifo = !empty && (full || (starve_q == SW'(STARVE_MAX)) || !pipe_valid_i);
      grant_pipe = pipe_valid_i && !grant_fifo;
      // rd=0 results are accepted but never occupy an entry.
      push       = lu_valid_i && !full && (lu_rd_addr_i != 5'd0);

      wr_ptr_d = push       ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = grant_fifo ? rd_ptr_q + 1'b1 : rd_ptr_q;

      case ({push, grant_fifo})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      starve_d = starve_q;
      if (empty || grant_fifo) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end

      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (grant_fifo && (head_addr != 5'd0)) begin
         rf_we_d   = 1'b1;
         rf_addr_d = head_addr;
         rf_data_d = head_data;
      end else if (grant_pipe && (pipe_rd_addr_i != 5'd0)) begin
         rf_we_d   = 1'b1;
         rf_addr_d = pipe_rd_addr_i;
         rf_data_d = pipe_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   // Storage needs no reset: entries are only read while count_q says they are valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= lu_rd_addr_i;
         data_mem[wr_ptr_q] <= lu_data_i;
      end
   end

   assign lu_ready_o   = !full;
   assign stall_o      = pipe_valid_i && !grant_pipe;
   assign rf_we_o      = rf_we_q;
   assign rf_rd_addr_o = rf_addr_q;
   assign rf_wdata_o   = rf_data_q;
   assign buf_count_o  = count_q;

`ifdef WB_ARB_BYPASS_EN
   // Covers the cycle where the RF write is pending and its read port still returns old data.
   assign rs1_fwd_valid_o = rf_we_q && (rf_addr_q == rs1_addr_i) && (rs1_addr_i != 5'd0);
   assign rs2_fwd_valid_o = rf_we_q && (rf_addr_q == rs2_addr_i) && (rs2_addr_i != 5'd0);
   assign rs1_fwd_data_o  = rf_data_q;
   assign rs2_fwd_data_o  = rf_data_q;
`else
   logic unused_rs;
   assign unused_rs       = ^{rs1_addr_i, rs2_addr_i};
   assign rs1_fwd_valid_o = 1'b0;
   assign rs2_fwd_valid_o = 1'b0;
   assign rs1_fwd_data_o  = '0;
   assign rs2_fwd_data_o  = '0;
`endif

   a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
      !(lu_valid_i && !lu_ready_o));

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int SMAX  = 4;
   localparam int XLEN  = 32;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            pipe_valid_i = 1'b0;
   logic [4:0]      pipe_rd_addr_i = '0;
   logic [XLEN-1:0] pipe_data_i = '0;
   logic            lu_valid_i = 1'b0;
   logic [4:0]      lu_rd_addr_i = '0;
   logic [XLEN-1:0] lu_data_i = '0;
   logic            lu_ready_o, stall_o, rf_we_o;
   logic [4:0]      rf_rd_addr_o;
   logic [XLEN-1:0] rf_wdata_o;
   logic [4:0]      rs1_addr_i = '0;
   logic [4:0]      rs2_addr_i = '0;
   logic            rs1_fwd_valid_o, rs2_fwd_valid_o;
   logic [XLEN-1:0] rs1_fwd_data_o, rs2_fwd_data_o;
   logic [$clog2(DEPTH):0] buf_count_o;

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX), .XLEN(XLEN)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .pipe_valid_i(pipe_valid_i), .pipe_rd_addr_i(pipe_rd_addr_i), .pipe_data_i(pipe_data_i),
      .lu_valid_i(lu_valid_i), .lu_rd_addr_i(lu_rd_addr_i), .lu_data_i(lu_data_i),
      .lu_ready_o(lu_ready_o), .stall_o(stall_o),
      .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_wdata_o(rf_wdata_o),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_fwd_valid_o(rs1_fwd_valid_o), .rs1_fwd_data_o(rs1_fwd_data_o),
      .rs2_fwd_valid_o(rs2_fwd_valid_o), .rs2_fwd_data_o(rs2_fwd_data_o),
      .buf_count_o(buf_count_o)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   // Reference model: FIFO contents as queues, starvation age, last register-file write.
   logic [4:0]      mq_addr [$];
   logic [XLEN-1:0] mq_data [$];
   int              starve = 0;
   logic            m_we = 1'b0;
   logic [4:0]      m_addr = '0;
   logic [XLEN-1:0] m_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 0 = idle, 1 = pipeline, 2 = FIFO head
   function automatic int model_grant();
      if (mq_addr.size() > 0 && (mq_addr.size() == DEPTH || starve == SMAX)) return 2;
      if (pipe_valid_i) return 1;
      if (mq_addr.size() > 0) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      mq_addr.delete();
      mq_data.delete();
      starve = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   task automatic check_outputs();
      int  g;
      logic e1, e2;
      g = model_grant();
      chk("lu_ready",  lu_ready_o,  mq_addr.size() < DEPTH);
      chk("stall",     stall_o,     pipe_valid_i && g != 1);
      chk("buf_count", buf_count_o, mq_addr.size());
      chk("rf_we",     rf_we_o,     m_we);
      chk("rf_addr",   rf_rd_addr_o, m_addr);
      chk("rf_wdata",  rf_wdata_o,  m_data);
`ifdef WB_ARB_BYPASS_EN
      e1 = m_we && m_addr == rs1_addr_i && rs1_addr_i != 0;
      e2 = m_we && m_addr == rs2_addr_i && rs2_addr_i != 0;
      chk("rs1_fwd_valid", rs1_fwd_valid_o, e1);
      chk("rs2_fwd_valid", rs2_fwd_valid_o, e2);
      chk("rs1_fwd_data",  rs1_fwd_data_o,  m_data);
      chk("rs2_fwd_data",  rs2_fwd_data_o,  m_data);
`else
      e1 = 1'b0;
      e2 = 1'b0;
      chk("rs1_fwd_valid", rs1_fwd_valid_o, e1);
      chk("rs2_fwd_valid", rs2_fwd_valid_o, e2);
      chk("rs1_fwd_data",  rs1_fwd_data_o,  0);
      chk("rs2_fwd_data",  rs2_fwd_data_o,  0);
`endif
   endtask

   // Samples the inputs, lets the clock edge happen, then advances the model.
   task automatic model_step();
      int g, sz;
      logic push;
      logic [4:0] pa; logic [XLEN-1:0] pd;
      logic [4:0] la; logic [XLEN-1:0] ld;
      g    = model_grant();
      sz   = mq_addr.size();
      push = lu_valid_i && sz < DEPTH && lu_rd_addr_i != 0;
      pa = pipe_rd_addr_i; pd = pipe_data_i;
      la = lu_rd_addr_i;   ld = lu_data_i;
      @(posedge clk_i);
      m_we = 1'b0;
      if (g == 1 && pa != 0) begin
         m_we = 1'b1; m_addr = pa; m_data = pd;
      end else if (g == 2) begin
         m_addr = mq_addr.pop_front();
         m_data = mq_data.pop_front();
         m_we   = 1'b1;
      end
      if (push) begin
         mq_addr.push_back(la);
         mq_data.push_back(ld);
      end
      if (g == 2 || sz == 0) starve = 0;
      else if (starve < SMAX) starve++;
   endtask

   task automatic cycle();
      #1;
      check_outputs();
      model_step();
      @(negedge clk_i);
   endtask

   task automatic idle_drain();
      pipe_valid_i = 1'b0;
      lu_valid_i   = 1'b0;
      for (int i = 0; i < 8 && mq_addr.size() > 0; i++) cycle();
      chk("drain_empty", buf_count_o, 0);
   endtask

   initial begin
      int found;
      int line_no;
      logic [XLEN-1:0] pipe_data_seed;
      @(negedge clk_i);
      #1;
      chk("reset_rf_we", rf_we_o, 0);
      chk("reset_count", buf_count_o, 0);
      chk("reset_lu_ready", lu_ready_o, 1);
      chk("reset_stall", stall_o, 0);
      chk("reset_rf_addr", rf_rd_addr_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
      $display("[TB] reset checked");

      // Pipeline-only write
      pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd5; pipe_data_i = 32'hDEADBEEF;
      cycle();
      pipe_valid_i = 1'b0;
      #1;
      chk("pipe_we", rf_we_o, 1);
      chk("pipe_addr", rf_rd_addr_o, 5);
      chk("pipe_data", rf_wdata_o, 32'hDEADBEEF);
      chk("pipe_stall", stall_o, 0);
      cycle();
      $display("[TB] pipeline write rd=5 done");

      // Bypass probe with a pending write rd=9
      pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd9; pipe_data_i = 32'h1234;
      cycle();
      pipe_valid_i = 1'b0; rs1_addr_i = 5'd9; rs2_addr_i = 5'd0;
      #1;
`ifdef WB_ARB_BYPASS_EN
      chk("byp_rs1_valid", rs1_fwd_valid_o, 1);
      chk("byp_rs1_data", rs1_fwd_data_o, 32'h1234);
`else
      chk("byp_rs1_valid", rs1_fwd_valid_o, 0);
      chk("byp_rs1_data", rs1_fwd_data_o, 0);
`endif
      chk("byp_rs2_valid", rs2_fwd_valid_o, 0);
      cycle();
      $display("[TB] bypass probe rd=9 done");

      // FIFO fill and override under a continuous pipeline stream
      pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd10; pipe_data_i = 32'hA0A0;
      lu_valid_i = 1'b1; lu_rd_addr_i = 5'd3; lu_data_i = 32'h33;
      cycle();
      lu_rd_addr_i = 5'd4; lu_data_i = 32'h44;
      cycle();
      lu_valid_i = 1'b0;
      #1;
      chk("full_count", buf_count_o, 2);
      chk("full_stall", stall_o, 1);
      chk("full_lu_ready", lu_ready_o, 0);
      cycle();
      #1;
      chk("override_addr", rf_rd_addr_o, 3);
      chk("override_data", rf_wdata_o, 32'h33);
      found = 0;
      for (int n = 1; n <= 10 && found == 0; n++) begin
         cycle();
         if (rf_we_o && rf_rd_addr_o == 5'd4) found = n;
      end
      chk("rd4_grant_delay", found, 5);
      $display("[TB] fifo fill/override done, rd4 after %0d cycles", found);
      idle_drain();

      // Starvation of a single entry
      pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd11; pipe_data_i = 32'hBEEF;
      lu_valid_i = 1'b1; lu_rd_addr_i = 5'd7; lu_data_i = 32'h77;
      cycle();
      lu_valid_i = 1'b0;
      found = 0;
      for (int k = 1; k <= 8 && found == 0; k++) begin
         #1;
         if (stall_o === 1'b1) found = k;
         cycle();
      end
      chk("starve_grant_cycle", found, 5);
      #1;
      chk("starve_rd7", rf_rd_addr_o, 7);
      $display("[TB] starvation head granted at cycle %0d", found);
      idle_drain();

      // rd=0 filtering
      pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd0; pipe_data_i = 32'h1;
      cycle();
      pipe_valid_i = 1'b0;
      #1;
      chk("pipe_rd0_we", rf_we_o, 0);
      lu_valid_i = 1'b1; lu_rd_addr_i = 5'd0; lu_data_i = 32'h2;
      cycle();
      lu_valid_i = 1'b0;
      #1;
      chk("lu_rd0_count", buf_count_o, 0);
      cycle();
      $display("[TB] rd0 filtering done");

      // Asynchronous reset between edges with a buffered entry and a pending write
      pipe_valid_i = 1'b1; pipe_rd_addr_i = 5'd5; pipe_data_i = 32'h55;
      lu_valid_i = 1'b1; lu_rd_addr_i = 5'd7; lu_data_i = 32'h77;
      cycle();
      pipe_valid_i = 1'b0; lu_valid_i = 1'b0;
      #1;
      chk("pre_rst_we", rf_we_o, 1);
      chk("pre_rst_count", buf_count_o, 1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("async_rst_we", rf_we_o, 0);
      chk("async_rst_count", buf_count_o, 0);
      chk("async_rst_addr", rf_rd_addr_o, 0);
      chk("async_rst_data", rf_wdata_o, 0);
      chk("async_rst_lu_ready", lu_ready_o, 1);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      $display("[TB] async reset done");

      // Randomized traffic
      line_no = 0;
      for (int c = 0; c < 2000; c++) begin
         pipe_valid_i   = ($urandom_range(0, 3) != 0);
         pipe_rd_addr_i = 5'($urandom_range(0, 7));
         pipe_data_seed = $urandom;
         pipe_data_i    = pipe_data_seed;
         lu_valid_i     = lu_ready_o && ($urandom_range(0, 2) == 0);
         lu_rd_addr_i   = 5'($urandom_range(0, 7));
         lu_data_i      = $urandom;
         rs1_addr_i     = 5'($urandom_range(0, 7));
         rs2_addr_i     = 5'($urandom_range(0, 7));
         cycle();
         if (c % 250 == 0) begin
            line_no++;
            $display("[TB] random cycle %0d: count=%0d we=%0b rd=%0d", c, buf_count_o, rf_we_o, rf_rd_addr_o);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
